// File: rtl/uart_pkg.sv
// uart_pkg: types and helpers shared by the UART receive path (and the future
// transmit path).
//   rx_state_t       receiver FSM states
//   PARITY_*         parity-mode encodings used by the PARITY parameter
//   expected_parity  parity bit the transmitter should have sent for a word
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Data narrower than 8 bits is passed zero-extended. Zero bits do not
    // change the XOR, so the result is the same.
    // Odd parity: data ^ parity_bit == 1.
    // Even parity: data ^ parity_bit == 0.
    function automatic logic expected_parity(input logic [7:0] data, input int mode);
        if (mode == PARITY_ODD) begin
            return ~(^data);
        end
        return ^data;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: generic synchronous show-ahead FIFO with registered outputs.
//   clk, srst      clock, synchronous active-high reset (flushes the FIFO)
//   push, din      write request and data; the write is dropped when full,
//                  unless a pop happens in the same cycle
//   full           FIFO holds DEPTH words
//   pop            consume the head word (ignored when empty)
//   empty, dout    registered; dout is the head word whenever !empty
//   overrun        one-cycle pulse after a push was dropped
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic             empty,
    output logic [WIDTH-1:0] dout,
    output logic             overrun
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic [CNT_W-1:0] remain;
    logic [WIDTH-1:0] head_reg;
    logic [WIDTH-1:0] head_next;
    logic             empty_reg;
    logic             overrun_reg;
    logic             do_pop;
    logic             do_push;

    assign full        = (count_reg == CNT_W'(DEPTH));
    assign do_pop      = pop && (count_reg != '0);
    // A pop in the same cycle frees a slot, so a push into a full FIFO is still taken.
    assign do_push     = push && (!full || do_pop);
    assign rd_ptr_next = rd_ptr_reg + PTR_W'(do_pop);
    assign remain      = count_reg - CNT_W'(do_pop);
    assign count_next  = remain + CNT_W'(do_push);

    // The head register is preloaded with the word that will be at the front
    // after this cycle. That is an older stored word if one remains.
    // Otherwise it is the word being pushed now (bypass path).
    always_comb begin
        head_next = head_reg;
        if (remain != '0) begin
            head_next = mem[rd_ptr_next];
        end else if (do_push) begin
            head_next = din;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            head_reg    <= '0;
            empty_reg   <= 1'b1;
            overrun_reg <= 1'b0;
        end else begin
            wr_ptr_reg  <= wr_ptr_reg + PTR_W'(do_push);
            rd_ptr_reg  <= rd_ptr_next;
            count_reg   <= count_next;
            head_reg    <= head_next;
            empty_reg   <= (count_next == '0);
            overrun_reg <= push && !do_push;
        end
    end

    assign empty   = empty_reg;
    assign dout    = head_reg;
    assign overrun = overrun_reg;

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver with 3-sample mid-bit majority voting, per-word
// parity/framing flags and a show-ahead output FIFO.
//   i_clk, i_reset     clock, synchronous active-high reset
//   i_serialIn         asynchronous RX line, idle high
//   o_valid, i_ready   head-word handshake; a pop happens when both are high
//   o_data             head word data (LSB received first)
//   o_parityErr        head word parity mismatch
//   o_frameErr         head word had a stop bit sampled low
//   o_overrun          one-cycle pulse when a completed word was dropped
//   o_busy             receiver is not idle
module uart_rx_fifo #(
    parameter int CLK_DIVIDE = 868,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_serialIn,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_parityErr,
    output logic                 o_frameErr,
    output logic                 o_overrun,
    output logic                 o_busy
);

    import uart_pkg::*;

    localparam int CNT_W = $clog2(CLK_DIVIDE);
    localparam int H     = CLK_DIVIDE / 2;
    localparam int FW    = DATA_BITS + 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIVIDE - 1);
    localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(H - 1);
    localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(H);
    localparam logic [CNT_W-1:0] CNT_DEC  = CNT_W'(H + 1);

    logic                 sync1_reg;
    logic                 rx_s_reg;
    rx_state_t            state_reg;
    rx_state_t            state_next;
    logic [CNT_W-1:0]     cnt_reg;
    logic [2:0]           bit_idx_reg;
    logic                 samp0_reg;
    logic                 samp1_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 parity_err_reg;
    logic                 frame_err_reg;
    logic                 armed_reg;
    logic                 busy_reg;
    logic                 decide;
    logic                 vote;
    logic                 last_data;
    logic                 last_stop;
    logic                 push;
    logic [FW-1:0]        push_word;
    logic [FW-1:0]        fifo_dout;
    logic                 fifo_empty;

    assign decide    = (cnt_reg == CNT_DEC);
    // The third sample is rx_s itself in the decision cycle.
    assign vote      = (samp0_reg & samp1_reg) | (samp0_reg & rx_s_reg) | (samp1_reg & rx_s_reg);
    assign last_data = (bit_idx_reg == 3'(DATA_BITS - 1));
    assign last_stop = (bit_idx_reg == 3'(STOP_BITS - 1));
    // The current stop-bit decision is folded in directly. The word is pushed
    // in the same cycle that decision is made.
    assign push_word = {frame_err_reg | ~vote, parity_err_reg, shift_reg};

    always_comb begin
        state_next = state_reg;
        push       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (armed_reg && !rx_s_reg) begin
                    state_next = START;
                end
            end
            START: begin
                if (decide) begin
                    state_next = vote ? IDLE : DATA;
                end
            end
            DATA: begin
                if (decide && last_data) begin
                    state_next = (PARITY != PARITY_NONE) ? uart_pkg::PARITY : STOP;
                end
            end
            uart_pkg::PARITY: begin
                if (decide) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (decide && last_stop) begin
                    state_next = IDLE;
                    push       = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync1_reg      <= 1'b1;
            rx_s_reg       <= 1'b1;
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            bit_idx_reg    <= '0;
            samp0_reg      <= 1'b1;
            samp1_reg      <= 1'b1;
            shift_reg      <= '0;
            parity_err_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            armed_reg      <= 1'b1;
            busy_reg       <= 1'b0;
        end else begin
            sync1_reg <= i_serialIn;
            rx_s_reg  <= sync1_reg;
            state_reg <= state_next;
            busy_reg  <= (state_reg != IDLE);
            if (state_reg == IDLE) begin
                cnt_reg        <= '0;
                bit_idx_reg    <= '0;
                parity_err_reg <= 1'b0;
                frame_err_reg  <= 1'b0;
                // The line must be seen high before the next start bit is
                // accepted. Without this, a held break would be received
                // over and over.
                if (rx_s_reg) begin
                    armed_reg <= 1'b1;
                end
            end else begin
                // Runs freely from the start-bit edge. The start bit's full
                // period is counted, so every decision point is at cnt = H+1.
                cnt_reg <= (cnt_reg == CNT_LAST) ? '0 : cnt_reg + CNT_W'(1);
                if (cnt_reg == CNT_S0) begin
                    samp0_reg <= rx_s_reg;
                end
                if (cnt_reg == CNT_S1) begin
                    samp1_reg <= rx_s_reg;
                end
                if (decide) begin
                    case (state_reg)
                        DATA: begin
                            shift_reg   <= {vote, shift_reg[DATA_BITS-1:1]};
                            bit_idx_reg <= last_data ? 3'd0 : bit_idx_reg + 3'd1;
                        end
                        uart_pkg::PARITY: begin
                            parity_err_reg <= (vote != expected_parity(8'(shift_reg), PARITY));
                        end
                        STOP: begin
                            if (!vote) begin
                                frame_err_reg <= 1'b1;
                            end
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                            if (last_stop) begin
                                armed_reg <= 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    uart_sync_fifo #(
        .WIDTH(FW),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (i_clk),
        .srst   (i_reset),
        .push   (push),
        .din    (push_word),
        .full   (),
        .pop    (i_ready),
        .empty  (fifo_empty),
        .dout   (fifo_dout),
        .overrun(o_overrun)
    );

    assign o_valid                              = ~fifo_empty;
    assign {o_frameErr, o_parityErr, o_data}    = fifo_dout;
    assign o_busy                               = busy_reg;

endmodule
